sha512block_ctrl: RTL and testbench

Address and control sequencer for one `sha512block` W-schedule/context memory. It runs one 80-round SHA-512 block per `start`:
- pulls 16 message words from the upstream word FIFO;
- drives all memory addresses, write enables and pipeline resets of `sha512block`;
- flags which cycles carry valid `Wt` and `block2ctx` data for the downstream round engine.

It sits between the per-unit input FIFO and the `sha512block` / round-engine pair.

---
 rtl/sha512block_ctrl_pkg.sv | 40 ++++
 rtl/sha512block_ctrl_if.sv | 40 ++++
 rtl/sha512block_ctrl_delay.sv | 23 ++
 rtl/sha512block_ctrl.sv | 144 ++++++++++++++
 tb/tb_sha512block_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha512block_ctrl_pkg.sv
// Shared types and constants for the sha512block address/control sequencer.
package sha512_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCtxld,
        StRounds,
        StPost,
        StSave,
        StDone
    } state_e;

    typedef struct packed {
        logic       ctx_sel;
        logic       seq_sel;
        logic       load_iv;
        logic [1:0] slot_in;
        logic       save_en;
        logic [1:0] slot_out;
    } cfg_t;

    localparam int unsigned IV_BASE     = 24;
    localparam int unsigned SLOT_BASE   = 32;
    localparam int unsigned SEQ_STRIDE  = 64;
    localparam int unsigned CTX_STRIDE  = 128;
    localparam int unsigned NUM_ROUNDS  = 80;
    localparam int unsigned BLOCK_WORDS = 16;
    localparam int unsigned CTX_WORDS   = 8;
    localparam int unsigned WR_ROUNDS   = 64;

    // First word of a context save slot.
    function automatic logic [7:0] slot_addr(logic ctx, logic seq, logic [1:0] slot);
        logic [7:0] a;
        a = 8'(SLOT_BASE) + {3'b000, slot, 3'b000};
        if (ctx) a = a + 8'(CTX_STRIDE);
        if (seq) a = a + 8'(SEQ_STRIDE);
        return a;
    endfunction

endpackage

// File: rtl/sha512block_ctrl_if.sv
// Control/handshake bundle between the sequencer, input FIFO, sha512block and round engine.
interface sha512block_ctrl_if;
    logic       start;
    logic       ctx_sel;
    logic       seq_sel;
    logic       load_iv;
    logic [1:0] slot_in;
    logic       save_en;
    logic [1:0] slot_out;
    logic       blk_avail;
    logic       in_rd;
    logic       external_input_en;
    logic       ctx_save_en;
    logic       mem_wr_en;
    logic [7:0] wr_addr;
    logic [7:0] rd_addr0;
    logic [7:0] rd_addr1;
    logic       W16_R1_rst;
    logic       R0_rst;
    logic       Wt_rst;
    logic       ctx_load;
    logic       round_en;
    logic [6:0] round_num;
    logic       post_en;
    logic       save_ack;
    logic       busy;
    logic       done;

    modport master (
        input  start, ctx_sel, seq_sel, load_iv, slot_in, save_en, slot_out, blk_avail, save_ack,
        output in_rd, external_input_en, ctx_save_en, mem_wr_en, wr_addr, rd_addr0, rd_addr1,
               W16_R1_rst, R0_rst, Wt_rst, ctx_load, round_en, round_num, post_en, busy, done
    );

    modport slave (
        output start, ctx_sel, seq_sel, load_iv, slot_in, save_en, slot_out, blk_avail, save_ack,
        input  in_rd, external_input_en, ctx_save_en, mem_wr_en, wr_addr, rd_addr0, rd_addr1,
               W16_R1_rst, R0_rst, Wt_rst, ctx_load, round_en, round_num, post_en, busy, done
    );
endinterface

// File: rtl/sha512block_ctrl_delay.sv
// Resettable shift-register delay line aligning issue-time controls with the datapath.
module ctrl_delay #(
    parameter int unsigned W = 1,
    parameter int unsigned N = 1
) (
    input  logic         CLK,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] pipe_q [N];

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int unsigned i = 1; i < N; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[N-1];
endmodule

// File: rtl/sha512block_ctrl.sv
// Sequences one 80-round SHA-512 block: context load, rounds, post-add reads and optional save.
module sha512block_ctrl
    import sha512_ctrl_pkg::*;
#(
    parameter int unsigned WR_LAT  = 4,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned RST_LAT = 1
) (
    input logic               CLK,
    input logic               rst_n,
    sha512block_ctrl_if.master bus
);
    state_e     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    cfg_t       cfg_q, cfg_d;

    logic [7:0] base, ctx_addr, save_addr;
    logic [3:0] t_m7, t_m15;
    logic       in_rounds, iss_wr, iss_rst, iss_ctxl, iss_post, save_beat;
    logic [7:0] iss_wra;
    logic [6:0] iss_num;
    logic       dl_wr, dl_ren;
    logic [7:0] dl_wra;
    logic [6:0] dl_num;
    logic       dl_ctxl, dl_post, dl_rst;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (bus.start && bus.blk_avail) begin
                    state_d = StCtxld;
                    cfg_d   = '{bus.ctx_sel, bus.seq_sel, bus.load_iv, bus.slot_in,
                                bus.save_en, bus.slot_out};
                end
            end
            StCtxld: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == 7'(CTX_WORDS - 1)) begin
                    state_d = StRounds;
                    cnt_d   = '0;
                end
            end
            StRounds: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == 7'(NUM_ROUNDS - 1)) begin
                    state_d = StPost;
                    cnt_d   = '0;
                end
            end
            // POST stays put until the last post_en has drained out of the read pipe.
            StPost: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == 7'(CTX_WORDS - 1 + RD_LAT)) begin
                    state_d = cfg_q.save_en ? StSave : StDone;
                    cnt_d   = '0;
                end
            end
            StSave: begin
                if (bus.save_ack) begin
                    cnt_d = cnt_q + 7'd1;
                    if (cnt_q == 7'(CTX_WORDS - 1)) begin
                        state_d = StDone;
                        cnt_d   = '0;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        base      = cfg_q.ctx_sel ? 8'(CTX_STRIDE) : 8'd0;
        ctx_addr  = (cfg_q.load_iv ? 8'(IV_BASE)
                                   : slot_addr(cfg_q.ctx_sel, cfg_q.seq_sel, cfg_q.slot_in))
                    + {5'd0, cnt_q[2:0]};
        save_addr = slot_addr(cfg_q.ctx_sel, cfg_q.seq_sel, cfg_q.slot_out) + {5'd0, cnt_q[2:0]};
        t_m7      = cnt_q[3:0] - 4'd7;
        t_m15     = cnt_q[3:0] - 4'd15;
        in_rounds = (state_q == StRounds);
        iss_wr    = in_rounds && (cnt_q < 7'(WR_ROUNDS));
        iss_wra   = iss_wr ? (base | {4'd0, cnt_q[3:0]}) : 8'd0;
        iss_num   = in_rounds ? cnt_q : 7'd0;
        iss_rst   = in_rounds && (cnt_q < 7'(BLOCK_WORDS));
        iss_ctxl  = (state_q == StCtxld);
        iss_post  = (state_q == StPost) && (cnt_q < 7'(CTX_WORDS));
        save_beat = (state_q == StSave) && bus.save_ack;
    end

    ctrl_delay #(.W(17), .N(WR_LAT)) u_wr_dly (
        .CLK   (CLK),
        .rst_n (rst_n),
        .d_i   ({iss_wr, iss_wra, in_rounds, iss_num}),
        .q_o   ({dl_wr, dl_wra, dl_ren, dl_num})
    );

    ctrl_delay #(.W(2), .N(RD_LAT)) u_rd_dly (
        .CLK   (CLK),
        .rst_n (rst_n),
        .d_i   ({iss_ctxl, iss_post}),
        .q_o   ({dl_ctxl, dl_post})
    );

    ctrl_delay #(.W(1), .N(RST_LAT)) u_rst_dly (
        .CLK   (CLK),
        .rst_n (rst_n),
        .d_i   (iss_rst),
        .q_o   (dl_rst)
    );

    assign bus.in_rd             = iss_rst;
    assign bus.external_input_en = iss_rst;
    assign bus.R0_rst            = dl_rst;
    assign bus.W16_R1_rst        = dl_rst;
    assign bus.rd_addr1          = iss_ctxl ? ctx_addr : in_rounds ? (base | {4'd0, t_m15}) : 8'd0;
    assign bus.rd_addr0          = (in_rounds && cnt_q >= 7'(BLOCK_WORDS)) ? (base | {4'd0, t_m7})
                                 : iss_post ? ctx_addr : 8'd0;
    assign bus.mem_wr_en         = dl_wr | save_beat;
    assign bus.wr_addr           = save_beat ? save_addr : dl_wra;
    assign bus.ctx_save_en       = (state_q == StSave);
    assign bus.ctx_load          = dl_ctxl;
    assign bus.post_en           = dl_post;
    assign bus.round_en          = dl_ren;
    assign bus.round_num         = dl_num;
    assign bus.Wt_rst            = !(in_rounds || dl_ren);
    assign bus.busy              = (state_q != StIdle);
    assign bus.done              = (state_q == StDone);
endmodule

// File: tb/tb_sha512block_ctrl.sv
// Directed self-checking bench for sha512block_ctrl; cycle 0 is the start-accept cycle.
module tb_sha512block_ctrl;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   done_cyc;

    logic [7:0] s_rd0 [256];
    logic [7:0] s_rd1 [256];
    logic [7:0] s_wra [256];
    logic [6:0] s_rnum[256];
    logic       s_wr  [256];
    logic       s_inrd[256];
    logic       s_ctxl[256];
    logic       s_ren [256];
    logic       s_post[256];
    logic       s_done[256];
    logic       s_wtr [256];
    logic       s_r0  [256];
    logic       s_csv [256];
    logic       s_busy[256];

    sha512block_ctrl_if bus ();

    sha512block_ctrl dut (
        .CLK   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one block and records every output per cycle, bounded to 200 cycles.
    task automatic run_block(input logic ctx, input logic seq, input logic liv,
                             input logic [1:0] sin, input logic sen, input logic [1:0] sout,
                             input bit gap_ack, input bit start_mid);
        for (int c = 0; c < 256; c++) begin
            s_rd0[c] = 0; s_rd1[c] = 0; s_wra[c] = 0; s_rnum[c] = 0; s_wr[c] = 0;
            s_inrd[c] = 0; s_ctxl[c] = 0; s_ren[c] = 0; s_post[c] = 0; s_done[c] = 0;
            s_wtr[c] = 0; s_r0[c] = 0; s_csv[c] = 0; s_busy[c] = 0;
        end
        done_cyc = -1;
        bus.ctx_sel = ctx; bus.seq_sel = seq; bus.load_iv = liv; bus.slot_in = sin;
        bus.save_en = sen; bus.slot_out = sout; bus.blk_avail = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c < 200; c++) begin
            bus.save_ack = gap_ack && (c % 2 == 1);
            bus.start    = start_mid && (c >= 30) && (c <= 40);
            #1;
            s_rd0[c] = bus.rd_addr0; s_rd1[c] = bus.rd_addr1; s_wra[c] = bus.wr_addr;
            s_rnum[c] = bus.round_num; s_wr[c] = bus.mem_wr_en; s_inrd[c] = bus.in_rd;
            s_ctxl[c] = bus.ctx_load; s_ren[c] = bus.round_en; s_post[c] = bus.post_en;
            s_done[c] = bus.done; s_wtr[c] = bus.Wt_rst; s_r0[c] = bus.R0_rst;
            s_csv[c] = bus.ctx_save_en; s_busy[c] = bus.busy;
            if (bus.done === 1'b1 && done_cyc < 0) done_cyc = c;
            @(posedge clk); #1;
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        bus.save_ack = 1'b0;
        bus.start    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.in_rd !== 1'b0 ||
            bus.mem_wr_en !== 1'b0 || bus.round_en !== 1'b0 || bus.ctx_load !== 1'b0 ||
            bus.post_en !== 1'b0 || bus.R0_rst !== 1'b0 || bus.ctx_save_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b done=%b in_rd=%b wr=%b ren=%b expected all 0",
                     bus.busy, bus.done, bus.in_rd, bus.mem_wr_en, bus.round_en);
        end
        n_chk++;
        if (bus.wr_addr !== 8'd0 || bus.rd_addr0 !== 8'd0 || bus.rd_addr1 !== 8'd0 ||
            bus.round_num !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_addr: wr=%0d rd0=%0d rd1=%0d num=%0d expected 0",
                     bus.wr_addr, bus.rd_addr0, bus.rd_addr1, bus.round_num);
        end
        n_chk++;
        if (bus.Wt_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wt_rst: got %b expected 1", bus.Wt_rst);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_iv_block();
        int cnt_ctxl, cnt_inrd, cnt_wr, cnt_post;
        run_block(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        n_chk++;
        if (done_cyc !== 99) begin
            n_fail++; $display("FAIL iv_done_cycle: got %0d expected 99", done_cyc);
        end
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (s_rd1[1+i] !== 8'(24 + i)) begin
                n_fail++; $display("FAIL iv_ctx_rd1[%0d]: got %0d expected %0d", i, s_rd1[1+i], 24 + i);
            end
            n_chk++;
            if (s_rd0[89+i] !== 8'(24 + i)) begin
                n_fail++; $display("FAIL iv_post_rd0[%0d]: got %0d expected %0d", i, s_rd0[89+i], 24 + i);
            end
        end
        cnt_ctxl = 0; cnt_inrd = 0; cnt_wr = 0; cnt_post = 0;
        for (int c = 0; c < 256; c++) begin
            if (s_ctxl[c] === 1'b1) cnt_ctxl++;
            if (s_inrd[c] === 1'b1) cnt_inrd++;
            if (s_wr[c] === 1'b1) cnt_wr++;
            if (s_post[c] === 1'b1) cnt_post++;
        end
        n_chk++;
        if (cnt_ctxl != 8 || s_ctxl[3] !== 1'b1 || s_ctxl[10] !== 1'b1 || s_ctxl[2] !== 1'b0) begin
            n_fail++; $display("FAIL iv_ctx_load: got %0d pulses expected 8 at cycles 3..10", cnt_ctxl);
        end
        n_chk++;
        if (cnt_inrd != 16 || s_inrd[9] !== 1'b1 || s_inrd[24] !== 1'b1) begin
            n_fail++; $display("FAIL iv_in_rd: got %0d pops expected 16 at cycles 9..24", cnt_inrd);
        end
        n_chk++;
        if (cnt_wr != 64) begin
            n_fail++; $display("FAIL iv_wr_count: got %0d expected 64", cnt_wr);
        end
        for (int c = 13; c <= 76; c += 5) begin
            n_chk++;
            if (s_wr[c] !== 1'b1 || s_wra[c] !== 8'((c - 13) % 16)) begin
                n_fail++;
                $display("FAIL iv_wr_addr@%0d: got en=%b addr=%0d expected en=1 addr=%0d",
                         c, s_wr[c], s_wra[c], (c - 13) % 16);
            end
        end
        n_chk++;
        if (cnt_post != 8 || s_post[91] !== 1'b1 || s_post[98] !== 1'b1) begin
            n_fail++; $display("FAIL iv_post_en: got %0d pulses expected 8 at cycles 91..98", cnt_post);
        end
        n_chk++;
        if (s_ren[12] !== 1'b0 || s_ren[13] !== 1'b1 || s_rnum[13] !== 7'd0 ||
            s_rnum[92] !== 7'd79 || s_ren[93] !== 1'b0 || s_rnum[93] !== 7'd0) begin
            n_fail++;
            $display("FAIL iv_round_en: got en13=%b num92=%0d en93=%b expected 1,79,0",
                     s_ren[13], s_rnum[92], s_ren[93]);
        end
        n_chk++;
        if (s_wtr[8] !== 1'b1 || s_wtr[9] !== 1'b0 || s_wtr[92] !== 1'b0 || s_wtr[93] !== 1'b1) begin
            n_fail++;
            $display("FAIL iv_wt_rst: got %b%b%b%b expected 1001", s_wtr[8], s_wtr[9], s_wtr[92], s_wtr[93]);
        end
        n_chk++;
        if (s_r0[9] !== 1'b0 || s_r0[10] !== 1'b1 || s_r0[25] !== 1'b1 || s_r0[26] !== 1'b0) begin
            n_fail++;
            $display("FAIL iv_r0_rst: got %b%b%b%b expected 0110", s_r0[9], s_r0[10], s_r0[25], s_r0[26]);
        end
        n_chk++;
        if (s_busy[100] !== 1'b0 || s_done[100] !== 1'b0) begin
            n_fail++; $display("FAIL iv_idle_after: got busy=%b done=%b expected 0 0", s_busy[100], s_done[100]);
        end
    endtask

    task automatic test_slot_block();
        run_block(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (s_rd1[1+i] !== 8'(240 + i)) begin
                n_fail++; $display("FAIL slot_ctx_rd1[%0d]: got %0d expected %0d", i, s_rd1[1+i], 240 + i);
            end
        end
        n_chk++;
        if (s_rd0[29] !== 8'd141 || s_rd1[29] !== 8'd133) begin
            n_fail++; $display("FAIL slot_t20: got rd0=%0d rd1=%0d expected 141 133", s_rd0[29], s_rd1[29]);
        end
        n_chk++;
        if (s_wra[13] !== 8'd128 || s_wra[76] !== 8'd143) begin
            n_fail++; $display("FAIL slot_wr_base: got %0d,%0d expected 128,143", s_wra[13], s_wra[76]);
        end
        n_chk++;
        if (s_rd0[89] !== 8'd240 || s_rd0[96] !== 8'd247) begin
            n_fail++; $display("FAIL slot_post_rd0: got %0d,%0d expected 240,247", s_rd0[89], s_rd0[96]);
        end
        n_chk++;
        if (done_cyc !== 99) begin
            n_fail++; $display("FAIL slot_done_cycle: got %0d expected 99", done_cyc);
        end
    endtask

    task automatic test_save_gapped();
        int cnt_wr;
        run_block(1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd3, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            n_chk++;
            if (s_wr[99+2*k] !== 1'b1 || s_wra[99+2*k] !== 8'(56 + k) || s_wr[100+2*k] !== 1'b0) begin
                n_fail++;
                $display("FAIL save_beat[%0d]: got en=%b addr=%0d gap_en=%b expected 1 %0d 0",
                         k, s_wr[99+2*k], s_wra[99+2*k], s_wr[100+2*k], 56 + k);
            end
        end
        cnt_wr = 0;
        for (int c = 0; c < 256; c++) if (s_wr[c] === 1'b1) cnt_wr++;
        n_chk++;
        if (cnt_wr != 72) begin
            n_fail++; $display("FAIL save_wr_count: got %0d expected 72", cnt_wr);
        end
        n_chk++;
        if (s_csv[98] !== 1'b0 || s_csv[99] !== 1'b1 || s_csv[113] !== 1'b1 || s_csv[114] !== 1'b0) begin
            n_fail++; $display("FAIL save_ctx_save_en: got %b%b%b%b expected 0110",
                               s_csv[98], s_csv[99], s_csv[113], s_csv[114]);
        end
        n_chk++;
        if (done_cyc !== 114) begin
            n_fail++; $display("FAIL save_done_cycle: got %0d expected 114", done_cyc);
        end
    endtask

    task automatic test_start_ignored();
        int cnt_inrd;
        bus.blk_avail = 1'b0;
        bus.start     = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            n_chk++;
            if (bus.busy !== 1'b0 || bus.in_rd !== 1'b0) begin
                n_fail++; $display("FAIL noavail_start[%0d]: got busy=%b in_rd=%b expected 0 0",
                                   c, bus.busy, bus.in_rd);
            end
        end
        bus.start = 1'b0;
        run_block(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        cnt_inrd = 0;
        for (int c = 0; c < 256; c++) if (s_inrd[c] === 1'b1) cnt_inrd++;
        n_chk++;
        if (cnt_inrd != 16 || done_cyc !== 99) begin
            n_fail++; $display("FAIL busy_start: got pops=%0d done=%0d expected 16 99", cnt_inrd, done_cyc);
        end
        n_chk++;
        if (s_busy[100] !== 1'b0 || s_busy[101] !== 1'b0) begin
            n_fail++; $display("FAIL busy_start_idle: got %b%b expected 00", s_busy[100], s_busy[101]);
        end
    endtask

    task automatic test_reset_mid();
        int cnt_wr;
        bus.ctx_sel = 1'b0; bus.seq_sel = 1'b0; bus.load_iv = 1'b1; bus.save_en = 1'b0;
        bus.blk_avail = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (48) @(posedge clk);
        #1;
        n_chk++;
        if (bus.mem_wr_en !== 1'b1 || bus.round_num !== 7'd36) begin
            n_fail++; $display("FAIL midrst_pre: got wr=%b num=%0d expected 1 36", bus.mem_wr_en, bus.round_num);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.mem_wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.round_en !== 1'b0 ||
            bus.Wt_rst !== 1'b1 || bus.rd_addr0 !== 8'd0 || bus.rd_addr1 !== 8'd0 ||
            bus.round_num !== 7'd0 || bus.wr_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_async: got wr=%b busy=%b ren=%b wt_rst=%b rd0=%0d expected 0 0 0 1 0",
                     bus.mem_wr_en, bus.busy, bus.round_en, bus.Wt_rst, bus.rd_addr0);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        cnt_wr = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.mem_wr_en === 1'b1) cnt_wr++;
        end
        n_chk++;
        if (cnt_wr != 0) begin
            n_fail++; $display("FAIL midrst_no_writes: got %0d writes expected 0", cnt_wr);
        end
        run_block(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        cnt_wr = 0;
        for (int c = 0; c < 256; c++) if (s_wr[c] === 1'b1) cnt_wr++;
        n_chk++;
        if (cnt_wr != 64 || done_cyc !== 99 || s_wra[13] !== 8'd0) begin
            n_fail++; $display("FAIL midrst_clean_block: got writes=%0d done=%0d expected 64 99",
                               cnt_wr, done_cyc);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        bus.start = 1'b0; bus.ctx_sel = 1'b0; bus.seq_sel = 1'b0; bus.load_iv = 1'b0;
        bus.slot_in = 2'd0; bus.save_en = 1'b0; bus.slot_out = 2'd0; bus.blk_avail = 1'b0;
        bus.save_ack = 1'b0;
        test_reset();
        test_iv_block();
        test_slot_block();
        test_save_gapped();
        test_start_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
